// File: rtl/zbt_arbiter.sv
// Two-port arbiter/sequencer in front of the zbt_6111 ZBT driver.
// Port 0 has fixed priority; port 1 is forced after STARVE_LIMIT denials.
module zbt_arbiter #(
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 36,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_cen,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  typedef enum logic {PRI0, FORCE1} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    tag_v;
  logic [2:0]    tag_p;
  logic          rd_acc;

  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    state_nx = state;
    cnt_nx   = cnt;
    if (!reset) begin
      unique case (state)
        PRI0: begin
          gnt0 = req0;
          gnt1 = req1 & ~req0;
          if (gnt1)
            cnt_nx = '0;
          else if (req1 && cnt != LIM)
            cnt_nx = cnt + 1'b1;
          if (cnt_nx == LIM)
            state_nx = FORCE1;
        end
        FORCE1: begin
          gnt1     = req1;
          cnt_nx   = '0;
          state_nx = PRI0;
        end
        default: state_nx = PRI0;
      endcase
    end
  end

  assign rd_acc = (gnt0 & ~we0) | (gnt1 & ~we1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= PRI0;
      cnt       <= '0;
      mem_cen   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      tag_v     <= '0;
      tag_p     <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      mem_cen <= 1'b1;
      mem_we  <= 1'b0;
      if (gnt0) begin
        mem_we    <= we0;
        mem_addr  <= addr0;
        mem_wdata <= wdata0;
      end else if (gnt1) begin
        mem_we    <= we1;
        mem_addr  <= addr1;
        mem_wdata <= wdata1;
      end
      // tag shifts in lockstep with the ZBT read pipeline
      tag_v <= {tag_v[1:0], rd_acc};
      tag_p <= {tag_p[1:0], gnt1};
    end
  end

  assign rvalid0 = tag_v[2] & ~tag_p[2] & ~reset;
  assign rvalid1 = tag_v[2] &  tag_p[2] & ~reset;
  assign rdata   = mem_rdata;

endmodule

// File: tb/tb_zbt_arbiter.sv
// Bench for zbt_arbiter: directed scenarios then random traffic,
// checked against a cycle-level model of grants, memory and read returns.
module tb_zbt_arbiter;

  localparam int AW  = 19;
  localparam int DW  = 36;
  localparam int LIM = 4;

  logic          clk = 0;
  logic          reset;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic          mem_cen, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  zbt_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata),
    .mem_cen(mem_cen), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // ZBT device: address presented in cycle K, data out in cycle K+2
  logic [DW-1:0] zmem [int];
  logic [DW-1:0] rd1 = '0, rd2 = '0;
  always @(posedge clk) begin
    if (mem_cen === 1'b1) begin
      if (mem_we)
        zmem[int'(mem_addr)] = mem_wdata;
      else
        rd1 <= zmem.exists(int'(mem_addr)) ?
               zmem[int'(mem_addr)] : '0;
    end
    rd2 <= rd1;
  end
  assign mem_rdata = rd2;

  // reference model state
  logic [DW-1:0] ref_mem [int];
  int            ring_p [8];
  logic [DW-1:0] ring_d [8];
  int            denied;
  int            cyc_n;
  logic          e_cen, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  int            errs, checks;

  logic          obs_g0, obs_g1, obs_rv0, obs_rv1, obs_we;
  logic [DW-1:0] obs_rd;
  logic [AW-1:0] obs_addr;
  logic          acc0, acc1;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d",
             tag, obs, exp, cyc_n);
    end
  endtask

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
  endfunction

  // one clock cycle: check at negedge, advance model, step past posedge
  task automatic cyc();
    logic eg0, eg1, forced;
    int   erv, slot;
    @(negedge clk);
    forced = (denied >= LIM);
    eg0 = ~reset & req0 & ~forced;
    eg1 = ~reset & req1 & (forced | ~req0);
    slot = cyc_n % 8;
    erv  = reset ? 0 : ring_p[slot];
    obs_g0 = gnt0; obs_g1 = gnt1;
    obs_rv0 = rvalid0; obs_rv1 = rvalid1;
    obs_rd = rdata; obs_addr = mem_addr; obs_we = mem_we;
    chk("gnt0", 64'(gnt0), 64'(eg0));
    chk("gnt1", 64'(gnt1), 64'(eg1));
    chk("mem_cen", 64'(mem_cen), 64'(e_cen));
    chk("mem_we", 64'(mem_we), 64'(e_we));
    chk("mem_addr", 64'(mem_addr), 64'(e_addr));
    chk("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
    chk("rvalid0", 64'(rvalid0), 64'(erv == 1));
    chk("rvalid1", 64'(rvalid1), 64'(erv == 2));
    chk("rv_excl", 64'(rvalid0 & rvalid1), 64'(0));
    if (erv != 0)
      chk("rdata", 64'(rdata), 64'(ring_d[slot]));
    ring_p[slot] = 0;
    acc0 = eg0;
    acc1 = eg1 & ~eg0;
    e_cen = ~reset;
    e_we  = 1'b0;
    if (reset) begin
      e_addr = '0; e_wdata = '0; denied = 0;
      for (int i = 0; i < 8; i++) ring_p[i] = 0;
    end else begin
      if (acc0 || acc1) begin
        e_we    = acc0 ? we0 : we1;
        e_addr  = acc0 ? addr0 : addr1;
        e_wdata = acc0 ? wdata0 : wdata1;
        if (e_we)
          ref_mem[int'(e_addr)] = e_wdata;
        else begin
          ring_p[(cyc_n + 3) % 8] = acc0 ? 1 : 2;
          ring_d[(cyc_n + 3) % 8] = ref_rd(e_addr);
        end
      end
      if (forced || eg1) denied = 0;
      else if (req1) denied++;
    end
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic idle();
    req0 = 0; req1 = 0;
  endtask

  logic [9:0]  gvec;
  int          g0cnt;
  logic        pend0, pend1;
  logic [63:0] r;

  initial begin
    errs = 0; checks = 0; cyc_n = 0; denied = 0;
    for (int i = 0; i < 8; i++) ring_p[i] = 0;
    reset = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (2) @(posedge clk);
    #1;
    e_cen = 0; e_we = 0; e_addr = '0; e_wdata = '0;
    req0 = 1;
    cyc();
    chk("rst_gnt0", 64'(obs_g0), 64'(0));
    reset = 0; idle();
    cyc();

    // single write then read by port 0
    req1 = 1; we1 = 1; addr1 = 19'h00010;
    wdata1 = 36'h123456789;
    cyc();
    idle(); cyc();
    req0 = 1; we0 = 0; addr0 = 19'h00010;
    cyc();
    chk("t1_gnt0", 64'(obs_g0), 64'(1));
    idle(); cyc();
    chk("t1_addr", 64'(obs_addr), 64'h10);
    chk("t1_we", 64'(obs_we), 64'(0));
    cyc();
    chk("t1_early", 64'(obs_rv0), 64'(0));
    cyc();
    chk("t1_rv0", 64'(obs_rv0), 64'(1));
    chk("t1_rd", 64'(obs_rd), 64'h123456789);
    cyc();
    chk("t1_late", 64'(obs_rv0), 64'(0));

    // back-to-back write then read, same address
    req1 = 1; we1 = 1; addr1 = 19'h7FFFF;
    wdata1 = 36'hAAAAAAAAA;
    cyc();
    chk("t2_gw", 64'(obs_g1), 64'(1));
    we1 = 0;
    cyc();
    chk("t2_gr", 64'(obs_g1), 64'(1));
    idle(); cyc(); cyc();
    chk("t2_early", 64'(obs_rv1), 64'(0));
    cyc();
    chk("t2_rv1", 64'(obs_rv1), 64'(1));
    chk("t2_rd", 64'(obs_rd), 64'hAAAAAAAAA);

    // interleaved reads
    req0 = 1; we0 = 0; addr0 = 19'h00010;
    cyc();
    req0 = 0; req1 = 1; we1 = 0; addr1 = 19'h7FFFF;
    cyc();
    req1 = 0; req0 = 1; addr0 = 19'h00020;
    cyc();
    idle();
    cyc();
    chk("t4_a_v", 64'({obs_rv0, obs_rv1}), 64'b10);
    chk("t4_a_d", 64'(obs_rd), 64'h123456789);
    cyc();
    chk("t4_b_v", 64'({obs_rv0, obs_rv1}), 64'b01);
    chk("t4_b_d", 64'(obs_rd), 64'hAAAAAAAAA);
    cyc();
    chk("t4_c_v", 64'({obs_rv0, obs_rv1}), 64'b10);
    chk("t4_c_d", 64'(obs_rd), 64'h0);

    // idle stretch
    repeat (10) cyc();
    chk("t6_addr", 64'(obs_addr), 64'h20);

    // reset while a read is in flight
    req0 = 1; we0 = 0; addr0 = 19'h00010;
    cyc();
    reset = 1;
    cyc();
    chk("t5_gnt_rst", 64'(obs_g0), 64'(0));
    cyc();
    chk("t5_cen_rst", 64'(mem_cen), 64'(0));
    reset = 0; idle();
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t5_norv", 64'(obs_rv0), 64'(0));
    end

    // starvation: both ports hold requests
    req0 = 1; we0 = 0; addr0 = 19'h00001;
    req1 = 1; we1 = 0; addr1 = 19'h00002;
    g0cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      gvec[i] = obs_g1;
      g0cnt += int'(obs_g0);
    end
    chk("t3_pattern", 64'(gvec), 64'(10'b1000010000));
    chk("t3_g0cnt", 64'(g0cnt), 64'(8));
    idle();
    repeat (4) cyc();

    // random traffic
    pend0 = 0; pend1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (!pend0 && $urandom_range(0, 2) != 0) begin
        pend0 = 1; we0 = $urandom_range(0, 1);
        addr0 = ($urandom_range(0, 8) == 8) ?
                19'h7FFFF : 19'($urandom_range(0, 7));
        r = {$urandom, $urandom}; wdata0 = r[DW-1:0];
      end
      if (!pend1 && $urandom_range(0, 2) != 0) begin
        pend1 = 1; we1 = $urandom_range(0, 1);
        addr1 = ($urandom_range(0, 8) == 8) ?
                19'h7FFFF : 19'($urandom_range(0, 7));
        r = {$urandom, $urandom}; wdata1 = r[DW-1:0];
      end
      req0 = pend0; req1 = pend1;
      reset = ($urandom_range(0, 79) == 0);
      cyc();
      if (acc0) pend0 = 0;
      if (acc1) pend1 = 0;
    end
    reset = 0; idle();
    repeat (6) cyc();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
